// File: rtl/bimodal_table_ctrl.sv
// bimodal_table_ctrl: sequences the bimodal counter RAM for lookups, saturating updates and flush sweeps
module bimodal_table_ctrl #(
  parameter int NUM_ENTRIES = 512,
  parameter int IDX_W = $clog2(NUM_ENTRIES),
  parameter int CTR_W = 2,
  parameter int UPD_DEPTH = 4,
  parameter logic [CTR_W-1:0] INIT_VAL = 'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             pred_valid_i,
  input  logic [IDX_W-1:0] pred_idx_i,
  output logic             pred_ready_o,
  output logic             pred_resp_v_o,
  output logic [CTR_W-1:0] pred_ctr_o,
  output logic             pred_taken_o,
  input  logic             upd_valid_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i,
  output logic             upd_ready_o,
  output logic             busy_o,
  output logic [IDX_W-1:0] ram_raddr_o,
  input  logic [CTR_W-1:0] ram_q_i,
  output logic             ram_we_o,
  output logic [IDX_W-1:0] ram_waddr_o,
  output logic [CTR_W-1:0] ram_wdata_o
);
  localparam int PTR_W = $clog2(UPD_DEPTH);
  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  typedef enum logic {RUN, SWEEP} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] fifo_idx_q [UPD_DEPTH];
  logic [IDX_W-1:0] fifo_idx_d [UPD_DEPTH];
  logic [UPD_DEPTH-1:0] fifo_tkn_q, fifo_tkn_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic rd_v_q, rd_v_d, rd_upd_q, rd_upd_d, rd_tkn_q, rd_tkn_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic fw_we_q, fw_we_d;
  logic [IDX_W-1:0] fw_addr_q, fw_addr_d;
  logic [CTR_W-1:0] fw_data_q, fw_data_d, hold_q, hold_d;
  logic run, full, pred_fire, pop, push, u2;
  logic [CTR_W-1:0] rd_data, new_ctr;
  // read-port arbitration, forwarding, saturating update and RAM write selection
  always_comb begin
    run = state_q == RUN;
    full = count_q == (PTR_W+1)'(UPD_DEPTH);
    pred_ready_o = run & ~flush_i & ~full;
    upd_ready_o = run & ~flush_i & ~full;
    pred_fire = pred_valid_i & pred_ready_o;
    pop = run & ~flush_i & ~pred_fire & (count_q != '0);
    push = upd_valid_i & upd_ready_o;
    ram_raddr_o = pred_fire ? pred_idx_i : pop ? fifo_idx_q[rd_ptr_q] : '0;
    rd_data = (fw_we_q && fw_addr_q == rd_idx_q) ? fw_data_q : ram_q_i;
    new_ctr = rd_tkn_q ? (rd_data == CTR_MAX ? rd_data : rd_data + CTR_W'(1))
                       : (rd_data == '0 ? rd_data : rd_data - CTR_W'(1));
    u2 = rd_v_q & rd_upd_q & ~flush_i;
    ram_we_o = ~run | u2;
    ram_waddr_o = ~run ? cnt_q : u2 ? rd_idx_q : '0;
    ram_wdata_o = ~run ? INIT_VAL : u2 ? new_ctr : '0;
    pred_resp_v_o = rd_v_q & ~rd_upd_q & ~flush_i;
    pred_ctr_o = pred_resp_v_o ? rd_data : hold_q;
    pred_taken_o = pred_ctr_o[CTR_W-1];
    busy_o = ~run | (count_q != '0) | (rd_v_q & rd_upd_q);
  end
  // next-state: sweep counter, update FIFO, read pipeline and write-forward register
  always_comb begin
    state_d = flush_i ? SWEEP : (~run && cnt_q == IDX_W'(NUM_ENTRIES-1)) ? RUN : state_q;
    cnt_d = flush_i ? '0 : ~run ? cnt_q + IDX_W'(1) : cnt_q;
    fifo_idx_d = fifo_idx_q;
    fifo_tkn_d = fifo_tkn_q;
    if (push) begin
      fifo_idx_d[wr_ptr_q] = upd_idx_i;
      fifo_tkn_d[wr_ptr_q] = upd_taken_i;
    end
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + PTR_W'(pop);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + PTR_W'(push);
    count_d = flush_i ? '0 : count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    rd_v_d = pred_fire | pop;
    rd_upd_d = pop;
    rd_idx_d = ram_raddr_o;
    rd_tkn_d = fifo_tkn_q[rd_ptr_q];
    fw_we_d = ram_we_o;
    fw_addr_d = ram_waddr_o;
    fw_data_d = ram_wdata_o;
    hold_d = pred_resp_v_o ? rd_data : hold_q;
  end
  // state registers with synchronous reset; RAM contents are never touched by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      fifo_idx_q <= '{default: '0};
      fifo_tkn_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      rd_v_q <= 1'b0;
      rd_upd_q <= 1'b0;
      rd_tkn_q <= 1'b0;
      rd_idx_q <= '0;
      fw_we_q <= 1'b0;
      fw_addr_q <= '0;
      fw_data_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fifo_idx_q <= fifo_idx_d;
      fifo_tkn_q <= fifo_tkn_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      rd_v_q <= rd_v_d;
      rd_upd_q <= rd_upd_d;
      rd_tkn_q <= rd_tkn_d;
      rd_idx_q <= rd_idx_d;
      fw_we_q <= fw_we_d;
      fw_addr_q <= fw_addr_d;
      fw_data_q <= fw_data_d;
      hold_q <= hold_d;
    end
  end
endmodule

// File: tb/tb_bimodal_table_ctrl.sv
// tb_bimodal_table_ctrl: directed and random checks of the bimodal table controller against a transaction model
module tb_bimodal_table_ctrl;
  localparam int N = 512;
  logic clk = 0, rst = 1, flush_i = 0, pred_valid_i = 0, upd_valid_i = 0, upd_taken_i = 0;
  logic [8:0] pred_idx_i = 0, upd_idx_i = 0, ram_raddr_o, ram_waddr_o;
  logic pred_ready_o, pred_resp_v_o, pred_taken_o, upd_ready_o, busy_o, ram_we_o;
  logic [1:0] pred_ctr_o, ram_q_i, ram_wdata_o;
  logic [1:0] mem [N];
  int vecs = 0, errs = 0;
  bit log_en = 0;
  int wlog_a[$], wlog_d[$];

  always #5 clk = ~clk;

  bimodal_table_ctrl dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i), .pred_ready_o(pred_ready_o),
    .pred_resp_v_o(pred_resp_v_o), .pred_ctr_o(pred_ctr_o), .pred_taken_o(pred_taken_o),
    .upd_valid_i(upd_valid_i), .upd_idx_i(upd_idx_i), .upd_taken_i(upd_taken_i),
    .upd_ready_o(upd_ready_o), .busy_o(busy_o), .ram_raddr_o(ram_raddr_o), .ram_q_i(ram_q_i),
    .ram_we_o(ram_we_o), .ram_waddr_o(ram_waddr_o), .ram_wdata_o(ram_wdata_o)
  );

  // 1R/1W synchronous RAM, read returns the old word on a same-cycle write
  always @(posedge clk) begin
    ram_q_i <= mem[ram_raddr_o];
    if (ram_we_o) mem[ram_waddr_o] <= ram_wdata_o;
  end

  task automatic chk(string name, int act, int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(int c, bit t);
    return t ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
  endfunction

  // transaction model: table contents, update queue and one cycle of in-flight reads
  int m[N];
  int q_idx[$];
  bit q_tkn[$];
  bit sweep, pu_v, pu_t, pp_v, e_full, e_rdy, e_rv, e_we, iss_p, iss_u, e_busy;
  int cnt, pu_i, pp_i, hold, e_ctr, e_wa, e_wd, e_ra;

  always @(negedge clk) begin
    if (log_en && ram_we_o) begin
      wlog_a.push_back(ram_waddr_o);
      wlog_d.push_back(ram_wdata_o);
    end
    if (rst) begin
      sweep = 0; cnt = 0; pu_v = 0; pp_v = 0; hold = 0;
      q_idx.delete(); q_tkn.delete();
    end else begin
      e_full = q_idx.size() == 4;
      e_rdy = !sweep && !flush_i && !e_full;
      e_rv = pp_v && !flush_i;
      e_ctr = e_rv ? m[pp_i] : hold;
      e_we = 0; e_wa = 0; e_wd = 0;
      if (sweep) begin e_we = 1; e_wa = cnt; e_wd = 1; end
      else if (pu_v && !flush_i) begin e_we = 1; e_wa = pu_i; e_wd = sat(m[pu_i], pu_t); end
      iss_p = e_rdy && pred_valid_i;
      iss_u = !sweep && !flush_i && !iss_p && q_idx.size() > 0;
      e_ra = iss_p ? int'(pred_idx_i) : iss_u ? q_idx[0] : 0;
      e_busy = sweep || q_idx.size() > 0 || pu_v;
      chk("pred_ready", pred_ready_o, e_rdy);
      chk("upd_ready", upd_ready_o, e_rdy);
      chk("resp_v", pred_resp_v_o, e_rv);
      chk("pred_ctr", pred_ctr_o, e_ctr);
      chk("pred_taken", pred_taken_o, e_ctr / 2);
      chk("ram_we", ram_we_o, e_we);
      if (e_we) begin
        chk("ram_waddr", ram_waddr_o, e_wa);
        chk("ram_wdata", ram_wdata_o, e_wd);
      end
      chk("ram_raddr", ram_raddr_o, e_ra);
      chk("busy", busy_o, e_busy);
      if (e_rv) hold = e_ctr;
      if (e_we) m[e_wa] = e_wd;
      pp_v = iss_p; pp_i = pred_idx_i; pu_v = iss_u;
      if (iss_u) begin pu_i = q_idx.pop_front(); pu_t = q_tkn.pop_front(); end
      if (upd_valid_i && e_rdy) begin q_idx.push_back(upd_idx_i); q_tkn.push_back(upd_taken_i); end
      if (flush_i) begin
        sweep = 1; cnt = 0; pp_v = 0; pu_v = 0;
        q_idx.delete(); q_tkn.delete();
      end else if (sweep) begin
        if (cnt == N - 1) sweep = 0; else cnt++;
      end
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(int lim);
    int k;
    for (k = 0; k < lim; k++) begin
      if (!busy_o) break;
      nxt();
    end
    if (k == lim) chk("idle_timeout", 1, 0);
  endtask

  task automatic lookup(int idx, int exp, string nm);
    int k;
    pred_valid_i = 1; pred_idx_i = 9'(idx);
    for (k = 0; k < 50 && !pred_ready_o; k++) nxt();
    if (k == 50) chk({nm, "_timeout"}, 1, 0);
    nxt();
    pred_valid_i = 0;
    @(negedge clk);
    chk({nm, "_resp_v"}, pred_resp_v_o, 1);
    chk({nm, "_ctr"}, pred_ctr_o, exp);
    chk({nm, "_taken"}, pred_taken_o, exp / 2);
    nxt();
  endtask

  task automatic push_upd(int idx, bit t);
    upd_valid_i = 1; upd_idx_i = 9'(idx); upd_taken_i = t;
    nxt();
    upd_valid_i = 0;
  endtask

  initial begin
    int bad;
    int exp5[3] = '{2, 3, 3};
    int exp9[6] = '{0, 0, 1, 2, 3, 3};
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_resp_v", pred_resp_v_o, 0);
    chk("rst_we", ram_we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_ctr", pred_ctr_o, 0);
    chk("rst_raddr", ram_raddr_o, 0);
    chk("rst_pred_ready", pred_ready_o, 1);
    chk("rst_upd_ready", upd_ready_o, 1);
    nxt();
    rst = 0;
    nxt();
    flush_i = 1;
    nxt();
    flush_i = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      chk("sweep_we", ram_we_o, 1);
      chk("sweep_addr", ram_waddr_o, i);
      chk("sweep_busy", busy_o, 1);
      chk("sweep_ready", pred_ready_o | upd_ready_o, 0);
      nxt();
    end
    @(negedge clk);
    chk("sweep_done_busy", busy_o, 0);
    nxt();
    lookup(7, 1, "lk7");
    wlog_a.delete(); wlog_d.delete(); log_en = 1;
    for (int i = 0; i < 3; i++) push_upd(5, 1);
    wait_idle(50);
    log_en = 0;
    chk("upd5_nwr", wlog_d.size(), 3);
    for (int i = 0; i < 3 && i < wlog_d.size(); i++) chk("upd5_wdata", wlog_d[i], exp5[i]);
    lookup(5, 3, "lk5");
    wlog_a.delete(); wlog_d.delete(); log_en = 1;
    for (int i = 0; i < 6; i++) push_upd(9, i >= 2);
    wait_idle(50);
    log_en = 0;
    chk("upd9_nwr", wlog_d.size(), 6);
    for (int i = 0; i < 6 && i < wlog_d.size(); i++) chk("upd9_wdata", wlog_d[i], exp9[i]);
    lookup(9, 3, "lk9");
    pred_valid_i = 1; pred_idx_i = 2;
    for (int i = 0; i < 4; i++) begin
      upd_valid_i = 1; upd_idx_i = 9'(20 + i); upd_taken_i = 1'($urandom);
      nxt();
    end
    upd_valid_i = 0;
    @(negedge clk);
    chk("full_pred_ready", pred_ready_o, 0);
    chk("full_upd_ready", upd_ready_o, 0);
    chk("full_pop_we", ram_we_o, 0);
    nxt();
    @(negedge clk);
    chk("drain_pred_ready", pred_ready_o, 1);
    nxt();
    pred_valid_i = 0;
    wait_idle(50);
    push_upd(3, 1);
    nxt();
    pred_valid_i = 1; pred_idx_i = 3;
    @(negedge clk);
    chk("fwd_we", ram_we_o, 1);
    chk("fwd_waddr", ram_waddr_o, 3);
    nxt();
    pred_valid_i = 0;
    @(negedge clk);
    chk("fwd_resp_v", pred_resp_v_o, 1);
    chk("fwd_ctr", pred_ctr_o, 2);
    nxt();
    wait_idle(50);
    pred_valid_i = 1; pred_idx_i = 4;
    upd_valid_i = 1; upd_idx_i = 10; upd_taken_i = 1;
    nxt();
    upd_idx_i = 11;
    nxt();
    pred_valid_i = 0; upd_valid_i = 0; flush_i = 1;
    @(negedge clk);
    chk("flush_resp_v", pred_resp_v_o, 0);
    chk("flush_we", ram_we_o, 0);
    nxt();
    flush_i = 0;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      if (pred_resp_v_o || (ram_we_o && ram_wdata_o != 2'b01)) bad++;
      nxt();
    end
    chk("flush_sweep_bad", bad, 0);
    wait_idle(50);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] != 2'b01) bad++;
    chk("flush_mem_bad", bad, 0);
    lookup(10, 1, "lk10");
    lookup(11, 1, "lk11");
    for (int c = 0; c < 4000; c++) begin
      pred_valid_i = 1'($urandom);
      pred_idx_i = 9'($urandom_range(0, 15));
      upd_valid_i = $urandom_range(0, 2) != 0;
      upd_idx_i = 9'($urandom_range(0, 15));
      upd_taken_i = 1'($urandom);
      flush_i = $urandom_range(0, 699) == 0;
      nxt();
    end
    pred_valid_i = 0; upd_valid_i = 0; flush_i = 0;
    wait_idle(700);
    bad = 0;
    for (int i = 0; i < N; i++) if (int'(mem[i]) != m[i]) bad++;
    chk("final_mem_bad", bad, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
